// File: rtl/vrf_read_responder.sv
// vrf_read_responder: issues VRF SRAM reads for arbitrated read requests and
// returns the data, in request order, through a credit-protected response FIFO.
// Credits cover reads still in the tag pipeline plus entries already queued, so
// a read that has been issued always finds a free FIFO slot when its data lands.
module vrf_read_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [4:0]            io_req_bits_vs,
    input  logic                  io_req_bits_offset,
    input  logic [3:0]            io_req_bits_readSource,
    input  logic [2:0]            io_req_bits_instructionIndex,
    input  logic                  io_writeBlock,
    output logic                  sram_ren,
    output logic [5:0]            sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [DATA_WIDTH-1:0] io_resp_bits_data,
    output logic [3:0]            io_resp_bits_readSource,
    output logic [2:0]            io_resp_bits_instructionIndex
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [3:0] src;
        logic [2:0] idx;
    } tag_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        tag_t                  tag;
    } entry_t;

    logic [READ_LATENCY-1:0] pv_q, pv_d;
    tag_t                    pt_q [READ_LATENCY];
    tag_t                    pt_d [READ_LATENCY];
    entry_t                  mem_q [RESP_DEPTH];
    entry_t                  mem_d [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [CNT_W-1:0]        inflight;
    logic [SUM_W-1:0]        credits_used;
    logic                    fire;
    logic                    push_req;
    logic                    push;
    logic                    pop;
    logic                    full;

    // Number of reads issued to the SRAM whose data has not yet been captured.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pv_q[i]);
        end
    end

    // A credit freed by a pop only shows up once count_q has updated, i.e. next cycle.
    assign credits_used = SUM_W'(inflight) + SUM_W'(count_q);
    assign io_req_ready = !io_writeBlock && (credits_used < SUM_W'(RESP_DEPTH));
    assign fire         = io_req_valid && io_req_ready;
    assign sram_ren     = fire;
    assign sram_addr    = {io_req_bits_vs, io_req_bits_offset};

    assign full     = (count_q == CNT_W'(RESP_DEPTH));
    assign push_req = pv_q[READ_LATENCY-1];
    assign push     = push_req && !full;
    assign io_resp_valid = (count_q != '0);
    assign pop      = io_resp_valid && io_resp_ready;

    assign io_resp_bits_data             = mem_q[rd_ptr_q].data;
    assign io_resp_bits_readSource       = mem_q[rd_ptr_q].tag.src;
    assign io_resp_bits_instructionIndex = mem_q[rd_ptr_q].tag.idx;

    // Tag pipeline: stage 0 loads on fire, later stages shift, last stage meets the SRAM data.
    always_comb begin
        pv_d = '0;
        pt_d = pt_q;
        pv_d[0] = fire;
        if (fire) begin
            pt_d[0] = '{src: io_req_bits_readSource, idx: io_req_bits_instructionIndex};
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
        end
    end

    // Response FIFO: push the returning word with its tags, pop on handshake.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: sram_rdata, tag: pt_q[READ_LATENCY-1]};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every in-flight and queued read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pv_q     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pt_q[i] <= '0;
            end
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pv_q     <= pv_d;
            pt_q     <= pt_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The credit check must make an overflowing push impossible.
    a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset) !(push_req && full));

endmodule

// File: tb/tb_vrf_read_responder.sv
// Directed bench for vrf_read_responder: one instance at READ_LATENCY=1 and one
// at READ_LATENCY=3, each with its own SRAM read-port model.
module tb_vrf_read_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A: READ_LATENCY = 1 ----------------
    logic        rst_n, req_valid, req_ready, off, wblk, ren, resp_valid, resp_ready;
    logic [4:0]  vs;
    logic [3:0]  src, r_src;
    logic [2:0]  idx, r_idx;
    logic [5:0]  addr;
    logic [31:0] rdata, r_data, a_rd;

    vrf_read_responder #(.DATA_WIDTH(32), .READ_LATENCY(1), .RESP_DEPTH(4)) dut (
        .clock(clock), .reset(rst_n),
        .io_req_valid(req_valid), .io_req_ready(req_ready),
        .io_req_bits_vs(vs), .io_req_bits_offset(off),
        .io_req_bits_readSource(src), .io_req_bits_instructionIndex(idx),
        .io_writeBlock(wblk), .sram_ren(ren), .sram_addr(addr), .sram_rdata(rdata),
        .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
        .io_resp_bits_data(r_data), .io_resp_bits_readSource(r_src),
        .io_resp_bits_instructionIndex(r_idx)
    );

    // ---------------- instance B: READ_LATENCY = 3 ----------------
    logic        b_rst_n, b_req_valid, b_req_ready, b_off, b_wblk, b_ren, b_resp_valid, b_resp_ready;
    logic [4:0]  b_vs;
    logic [3:0]  b_src, b_r_src;
    logic [2:0]  b_idx, b_r_idx;
    logic [5:0]  b_addr;
    logic [31:0] b_rdata, b_r_data, b_p0, b_p1, b_p2;

    vrf_read_responder #(.DATA_WIDTH(32), .READ_LATENCY(3), .RESP_DEPTH(4)) dut3 (
        .clock(clock), .reset(b_rst_n),
        .io_req_valid(b_req_valid), .io_req_ready(b_req_ready),
        .io_req_bits_vs(b_vs), .io_req_bits_offset(b_off),
        .io_req_bits_readSource(b_src), .io_req_bits_instructionIndex(b_idx),
        .io_writeBlock(b_wblk), .sram_ren(b_ren), .sram_addr(b_addr), .sram_rdata(b_rdata),
        .io_resp_valid(b_resp_valid), .io_resp_ready(b_resp_ready),
        .io_resp_bits_data(b_r_data), .io_resp_bits_readSource(b_r_src),
        .io_resp_bits_instructionIndex(b_r_idx)
    );

    // SRAM contents: 0x0B holds 0xDEADBEEF, every other address a distinct pattern.
    function automatic logic [31:0] mem_val(input logic [5:0] a);
        return (a == 6'h0B) ? 32'hDEADBEEF : {8'h5A, 2'b00, a, 10'h3C1, a};
    endfunction

    // SRAM read-port models with the matching latency.
    always @(posedge clock) begin
        a_rd <= mem_val(addr);
        b_p0 <= mem_val(b_addr);
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign rdata   = a_rd;
    assign b_rdata = b_p2;

    // Request encodings {vs, offset, readSource, instructionIndex}.
    function automatic logic [12:0] fill_req(input int k);
        logic [4:0] v = 5'(8 + k);
        return {v, k[0], 4'(k), 3'(k)};
    endfunction

    function automatic logic [12:0] ord_req(input int k);
        logic [4:0] v = 5'(16 + k);
        return {v, k[0], 4'(k ^ 5), 3'(k)};
    endfunction

    // Expected response {data, readSource, instructionIndex} for a request encoding.
    function automatic logic [38:0] exp_of(input logic [12:0] r);
        return {mem_val(r[12:7]), r[6:3], r[2:0]};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; b_rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({resp_valid, ren, req_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid/ren/ready=%b want 001", {resp_valid, ren, req_ready});
        end
        n_cmp++;
        if ({r_data, r_src, r_idx} !== 39'h0) begin
            n_err++;
            $display("FAIL reset_bits: got %h want 0", {r_data, r_src, r_idx});
        end
        n_cmp++;
        if ({b_resp_valid, b_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_b: got valid/ready=%b want 01", {b_resp_valid, b_req_ready});
        end
        wblk = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wblk_ready: got %b want 0", req_ready);
        end
        wblk = 1'b0;
        rst_n = 1'b1; b_rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        step();
        resp_ready = 1'b1;
        req_valid = 1'b1; vs = 5'd5; off = 1'b1; src = 4'h3; idx = 3'd2;
        #1;
        n_cmp++;
        if ({ren, addr, req_ready} !== {1'b1, 6'h0B, 1'b1}) begin
            n_err++;
            $display("FAIL single_issue: got ren=%b addr=%h ready=%b want 1 0b 1", ren, addr, req_ready);
        end
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: got valid=%b want 0 at t+1", resp_valid);
        end
        step();
        n_cmp++;
        if ({resp_valid, r_data, r_src, r_idx} !== {1'b1, 32'hDEADBEEF, 4'h3, 3'd2}) begin
            n_err++;
            $display("FAIL single_resp: got v=%b %h/%h/%0d want 1 deadbeef/3/2", resp_valid, r_data, r_src, r_idx);
        end
        step();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_popped: got valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_back_pressure();
        int nacc = 0;
        resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            {vs, off, src, idx} = fill_req(nacc);
            #1;
            if (req_ready) nacc++;
            step();
        end
        n_cmp++;
        if (nacc !== 4 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_fill: got accepted=%0d ready=%b want 4 0", nacc, req_ready);
        end
        n_cmp++;
        if ({resp_valid, r_data, r_src, r_idx} !== {1'b1, exp_of(fill_req(0))}) begin
            n_err++;
            $display("FAIL bp_head: got v=%b %h want 1 %h", resp_valid, {r_data, r_src, r_idx}, exp_of(fill_req(0)));
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_same_cycle_credit: got ready=%b want 0", req_ready);
        end
        step();
        resp_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_credit_next: got ready=%b want 1", req_ready);
        end
        resp_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if ({resp_valid, r_data, r_src, r_idx} !== {1'b1, exp_of(fill_req(k))}) begin
                n_err++;
                $display("FAIL bp_drain_%0d: got v=%b %h want 1 %h", k, resp_valid, {r_data, r_src, r_idx}, exp_of(fill_req(k)));
            end
            step();
        end
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: got valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_write_block();
        resp_ready = 1'b1;
        req_valid = 1'b1; vs = 5'd20; off = 1'b0; src = 4'h9; idx = 3'd5;
        wblk = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({ren, req_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL wblk_cycle_%0d: got ren/ready=%b want 00", c, {ren, req_ready});
            end
            step();
        end
        wblk = 1'b0;
        #1;
        n_cmp++;
        if ({ren, addr} !== {1'b1, 6'd40}) begin
            n_err++;
            $display("FAIL wblk_release: got ren=%b addr=%h want 1 28", ren, addr);
        end
        step();
        req_valid = 1'b0;
        step();
        n_cmp++;
        if ({resp_valid, r_data, r_src, r_idx} !== {1'b1, mem_val(6'd40), 4'h9, 3'd5}) begin
            n_err++;
            $display("FAIL wblk_resp: got v=%b %h want 1 %h", resp_valid, {r_data, r_src, r_idx}, {mem_val(6'd40), 4'h9, 3'd5});
        end
        step();
    endtask

    task automatic test_order_wrap();
        logic [38:0] q[$];
        int nsent = 0;
        int nrecv = 0;
        for (int cyc = 0; cyc < 200 && nrecv < 12; cyc++) begin
            resp_ready = (cyc % 2 == 0);
            if (nsent < 12) begin
                req_valid = 1'b1;
                {vs, off, src, idx} = ord_req(nsent);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (req_valid && req_ready) begin
                q.push_back(exp_of(ord_req(nsent)));
                nsent++;
            end
            if (resp_valid && resp_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL order_resp_%0d: got %h want no response", nrecv, {r_data, r_src, r_idx});
                end else begin
                    if ({r_data, r_src, r_idx} !== q[0]) begin
                        n_err++;
                        $display("FAIL order_resp_%0d: got %h want %h", nrecv, {r_data, r_src, r_idx}, q[0]);
                    end
                    void'(q.pop_front());
                end
                nrecv++;
            end
            step();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (nsent !== 12 || nrecv !== 12) begin
            n_err++;
            $display("FAIL order_count: got sent=%0d recv=%0d want 12 12", nsent, nrecv);
        end
    endtask

    task automatic test_latency_sweep();
        int nacc = 0;
        int first_c = -1;
        int last_c = -1;
        b_resp_ready = 1'b1;
        step();
        b_req_valid = 1'b1; b_vs = 5'd3; b_off = 1'b0; b_src = 4'h7; b_idx = 3'd1;
        #1;
        n_cmp++;
        if ({b_ren, b_addr} !== {1'b1, 6'd6}) begin
            n_err++;
            $display("FAIL lat3_issue: got ren=%b addr=%h want 1 06", b_ren, b_addr);
        end
        step();
        b_req_valid = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            n_cmp++;
            if (b_resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL lat3_early_t%0d: got valid=%b want 0", d, b_resp_valid);
            end
            step();
        end
        n_cmp++;
        if ({b_resp_valid, b_r_data, b_r_src, b_r_idx} !== {1'b1, mem_val(6'd6), 4'h7, 3'd1}) begin
            n_err++;
            $display("FAIL lat3_resp: got v=%b %h want 1 %h", b_resp_valid, {b_r_data, b_r_src, b_r_idx}, {mem_val(6'd6), 4'h7, 3'd1});
        end
        step();
        b_resp_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b_req_valid = 1'b1;
            {b_vs, b_off, b_src, b_idx} = fill_req(nacc);
            #1;
            if (b_req_ready) begin
                if (first_c < 0) first_c = i;
                last_c = i;
                nacc++;
            end
            step();
        end
        b_req_valid = 1'b0;
        n_cmp++;
        if (nacc !== 4 || first_c !== 0 || last_c !== 3 || b_req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_stream: got acc=%0d first=%0d last=%0d ready=%b want 4 0 3 0", nacc, first_c, last_c, b_req_ready);
        end
        b_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({b_resp_valid, b_r_data, b_r_src, b_r_idx} !== {1'b1, exp_of(fill_req(k))}) begin
                n_err++;
                $display("FAIL lat3_drain_%0d: got v=%b %h want 1 %h", k, b_resp_valid, {b_r_data, b_r_src, b_r_idx}, exp_of(fill_req(k)));
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        logic any_valid = 1'b0;
        b_resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b_req_valid = 1'b1;
            {b_vs, b_off, b_src, b_idx} = ord_req(k);
            step();
        end
        b_req_valid = 1'b0;
        step();
        n_cmp++;
        if (b_resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_queued: got valid=%b want 1", b_resp_valid);
        end
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        n_cmp++;
        if ({b_resp_valid, b_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_after: got valid/ready=%b want 01", {b_resp_valid, b_req_ready});
        end
        b_resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (b_resp_valid) any_valid = 1'b1;
        end
        n_cmp++;
        if (any_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_stale: got stale response=%b want 0", any_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; vs = '0; off = 1'b0; src = '0; idx = '0;
        wblk = 1'b0; resp_ready = 1'b0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_vs = '0; b_off = 1'b0; b_src = '0; b_idx = '0;
        b_wblk = 1'b0; b_resp_ready = 1'b0;
        test_reset();
        test_single_read();
        test_back_pressure();
        test_write_block();
        test_order_wrap();
        test_latency_sweep();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vrf_read_responder.md
# vrf_read_responder

Responder end of the VRF read-request channel. It accepts read requests carrying `vs`/`offset`/`readSource`/`instructionIndex` from the read-stage arbiter and drives a fixed-latency VRF SRAM read port. It returns the read data tagged with its source and instruction index through a credit-protected response FIFO. The block sits between the lane's read-stage arbitration and the VRF bank. It is the only path by which read data leaves the bank toward the lane's consumers.

## Interface
- `DATA_WIDTH`, 32: width of one VRF read word.
- `READ_LATENCY`, 1: cycles from `sram_ren` to valid `sram_rdata`; legal 1..3.
- `RESP_DEPTH`, 4: response FIFO entries; must be ≥ `READ_LATENCY`+1, power of two.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `io_req_valid`  in  1  read request valid.
- `io_req_ready`  out  1  responder can accept a request this cycle.
- `io_req_bits_vs`  in  5  vector register index.
- `io_req_bits_offset`  in  1  half-register offset.
- `io_req_bits_readSource`  in  4  requester tag, returned unchanged.
- `io_req_bits_instructionIndex`  in  3  instruction tag, returned unchanged.
- `io_writeBlock`  in  1  VRF write owns the bank this cycle; no read may issue.
- `sram_ren`  out  1  SRAM read enable.
- `sram_addr`  out  6  `{vs, offset}`.
- `sram_rdata`  in  DATA_WIDTH  SRAM data, valid `READ_LATENCY` cycles after `sram_ren`.
- `io_resp_valid`  out  1  response valid.
- `io_resp_ready`  in  1  consumer accepts response.
- `io_resp_bits_data`  out  DATA_WIDTH  read data.
- `io_resp_bits_readSource`  out  4  echoed tag.
- `io_resp_bits_instructionIndex`  out  3  echoed tag.

## Operation
- A request fires when `io_req_valid && io_req_ready`.
- `io_req_ready = !io_writeBlock && (inflight + fifoCount) < RESP_DEPTH`. It is combinational and does not depend on `io_req_valid`.
- `sram_ren` equals the request-fire signal in the same cycle. `sram_addr = {vs, offset}` is driven combinationally from the request bits.
- The tag pipeline is a `READ_LATENCY`-stage shift register of {valid, readSource, instructionIndex}, loaded on fire. When stage `READ_LATENCY` is valid, `sram_rdata` is pushed with its tags into the FIFO at the end of that cycle.
- `inflight` counts valid pipeline stages. `fifoCount` counts FIFO entries, with width clog2(`RESP_DEPTH`+1).
- The FIFO pops on `io_resp_valid && io_resp_ready`. Push and pop in the same cycle leave the count unchanged.
- The credit check guarantees a push never meets a full FIFO. A push when full is an assertion failure and must not corrupt state.
- Head-of-FIFO drives the `io_resp_bits_*` outputs; `io_resp_valid = fifoCount != 0`. While valid and not ready, the response bits are held stable.
- Responses return strictly in request order.

## Timing
- Reset (`reset`=0 at an edge) clears all pipeline valids, FIFO pointers and counts.
- Reset values of the outputs:
  - `io_resp_valid`=0 and `sram_ren`=0.
  - `io_req_ready`=1 unless `io_writeBlock` is high.
  - `io_resp_bits_*`=0.
- Reset mid-operation discards all in-flight and queued reads; no response appears afterwards.
- Latency: request fires in cycle t → `io_resp_valid` in cycle t+`READ_LATENCY`+1 when the FIFO was empty. There is no bypass.
- Throughput is one request per cycle while credits remain.
- A credit freed by a pop in cycle t becomes usable for `io_req_ready` in cycle t+1, not the same cycle.
- `io_writeBlock` in cycle t forces `io_req_ready`=0 in cycle t only. In-flight reads and responses are unaffected.
- FIFO pointer wrap-around is modulo `RESP_DEPTH` with no bubble.

## Test plan
- Single read: write SRAM model addr 0x0B = 0xDEADBEEF. Issue vs=5, offset=1, readSource=0x3, instructionIndex=2 at cycle 10. Expect `sram_ren`=1 and `sram_addr`=0x0B at cycle 10. Expect the response at cycle 12 (LAT=1) carrying 0xDEADBEEF/0x3/2.
- Back-pressure fill: hold `io_resp_ready`=0 and drive continuous valid. Exactly 4 requests must be accepted, then `io_req_ready`=0. Release ready for one cycle: one response pops, and `io_req_ready`=1 in the next cycle.
- Write block: assert `io_writeBlock` for cycles 20–22 with a valid request pending. Expect no `sram_ren` in cycles 20–22 and the request accepted at cycle 23.
- Ordering/wrap: issue 12 back-to-back requests with `io_resp_ready` toggling 1/0. Expect 12 responses in issue order with correct tags, crossing pointer wrap twice.
- Latency sweep: with READ_LATENCY=3 and RESP_DEPTH=4, fire at cycle t and expect the response at t+4. Sustained streaming stalls only when `inflight`+`fifoCount` reaches 4.
- Reset mid-stream: pull `reset` low for 1 cycle with 2 reads in flight and 2 queued. Afterwards expect `io_resp_valid`=0 with no stale responses, and `io_req_ready`=1.
